// File: rtl/alu_controller.sv
// Multi-cycle ALU controller: captures op/A/B on start, computes the result in
// EXEC or over several ITER cycles, and writes it back once to register.
module alu_controller (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [3:0] A,
  output logic       busy,
  output logic       done,
  output logic [7:0] register
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned OP_W   = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state, w_state_n;
  logic [OP_W-1:0]   r_op, w_op_n;
  logic [NIB_W-1:0]  r_a, w_a_n;
  logic [NIB_W-1:0]  r_b, w_b_n;
  logic [DATA_W-1:0] r_acc, w_acc_n;
  logic [NIB_W-1:0]  r_cnt, w_cnt_n;
  logic [DATA_W-1:0] r_reg, w_reg_n;
  logic              r_busy, w_busy_n;
  logic              r_done, w_done_n;

  logic [NIB_W:0]    w_sum;
  logic [1:0]        w_mul_idx;
  logic [DATA_W-1:0] w_partial;

  // Adder and shift-add partial product; the bit index runs 0..3 as cnt counts 4..1
  assign w_sum     = 5'(r_a) + 5'(r_b);
  assign w_mul_idx = 2'(4'd4 - r_cnt);
  assign w_partial = 8'(r_a) << w_mul_idx;

  always_comb begin
    w_state_n = r_state;
    w_op_n    = r_op;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_acc_n   = r_acc;
    w_cnt_n   = r_cnt;
    w_reg_n   = r_reg;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_op_n    = op;
          w_a_n     = A;
          w_b_n     = r_reg[3:0];
          w_state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_n = S_DONE;
        case (r_op)
          3'd0: w_reg_n = {3'b000, w_sum};
          3'd1: w_reg_n = 8'(w_sum);
          3'd2: w_reg_n = {r_a | r_b, r_a ^ r_b};
          3'd3: w_reg_n = ((r_a != 4'd0) || (r_b != 4'd0)) ? 8'h18 : 8'h00;
          3'd4: w_reg_n = ((r_a == 4'hF) && (r_b == 4'hF)) ? 8'hE7 : 8'h00;
          3'd5: begin
            w_acc_n = 8'(r_a);
            w_cnt_n = r_b;
            if (r_b == 4'd0) w_reg_n   = 8'(r_a);
            else             w_state_n = S_ITER;
          end
          3'd6: begin
            w_acc_n   = 8'h00;
            w_cnt_n   = 4'd4;
            w_state_n = S_ITER;
          end
          default: ;
        endcase
      end
      S_ITER: begin
        w_cnt_n = r_cnt - 4'd1;
        if (r_op == 3'd5)         w_acc_n = r_acc << 1;
        else if (r_b[w_mul_idx])  w_acc_n = r_acc + w_partial;
        if (w_cnt_n == 4'd0) begin
          w_reg_n   = w_acc_n;
          w_state_n = S_DONE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    w_busy_n = (w_state_n != S_IDLE);
    w_done_n = (w_state_n == S_DONE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_reg   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_op    <= w_op_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_acc   <= w_acc_n;
      r_cnt   <= w_cnt_n;
      r_reg   <= w_reg_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign register = r_reg;

endmodule
